// File: rtl/mips_defs.sv
// Shared MIPS control constants: opcodes, functs, datapath select encodings,
// sequencer state encodings and the decoded instruction-class bundle.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd6;

    localparam logic [2:0] RD_RT    = 3'd0;
    localparam logic [2:0] RD_RD    = 3'd1;
    localparam logic [2:0] RD_RA    = 3'd2;

    localparam logic [2:0] M2R_ALU  = 3'd0;
    localparam logic [2:0] M2R_DM   = 3'd1;
    localparam logic [2:0] M2R_PC4  = 3'd2;

    localparam logic [2:0] PCS_PC4  = 3'd0;
    localparam logic [2:0] PCS_BR   = 3'd1;
    localparam logic [2:0] PCS_JAL  = 3'd2;
    localparam logic [2:0] PCS_RS   = 3'd3;

    localparam logic [2:0] DM_NONE  = 3'd0;
    localparam logic [2:0] DM_WORD  = 3'd1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef struct packed {
        logic add;
        logic sub;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic jal;
        logic jr;
        logic nop;
        logic ill;
    } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Latched opcode/funct to one-hot instruction class; anything undecoded is ill.
module instr_class_dec
    import mips_defs::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] fn_i,
    output iclass_t    cls_o
);

    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_RTYPE: begin
                case (fn_i)
                    FN_ADD:  cls_o.add = 1'b1;
                    FN_SUB:  cls_o.sub = 1'b1;
                    FN_JR:   cls_o.jr  = 1'b1;
                    FN_NOP:  cls_o.nop = 1'b1;
                    default: cls_o.ill = 1'b1;
                endcase
            end
            OP_ORI:  cls_o.ori = 1'b1;
            OP_LW:   cls_o.lw  = 1'b1;
            OP_SW:   cls_o.sw  = 1'b1;
            OP_BEQ:  cls_o.beq = 1'b1;
            OP_LUI:  cls_o.lui = 1'b1;
            OP_JAL:  cls_o.jal = 1'b1;
            default: cls_o.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with a DM ready
// handshake, retired-instruction counter and illegal-encoding pulse.
module multicycle_ctrl
    import mips_defs::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [2:0]       PCSrc,
    output logic             RegWrite,
    output logic [2:0]       RegDst,
    output logic [2:0]       MemtoReg,
    output logic             MemWrite,
    output logic             mem_req,
    output logic [2:0]       ALUOp,
    output logic             ALUSrc,
    output logic             ExtOp,
    output logic [2:0]       DMOp,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [5:0]       op_q, fn_q;
    logic [CNT_W-1:0] retired_q;
    iclass_t          cls;

    instr_class_dec u_dec (
        .op_i  (op_q),
        .fn_i  (fn_q),
        .cls_o (cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            fn_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = PCS_PC4;
        RegWrite   = 1'b0;
        RegDst     = RD_RT;
        MemtoReg   = M2R_ALU;
        MemWrite   = 1'b0;
        mem_req    = 1'b0;
        ALUOp      = ALU_NONE;
        ALUSrc     = 1'b0;
        ExtOp      = 1'b0;
        DMOp       = DM_NONE;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls.jal) begin
                    state_d = S_WB;
                end else if (cls.jr) begin
                    PCWrite    = 1'b1;
                    PCSrc      = PCS_RS;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (cls.nop || cls.ill) begin
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                    illegal    = cls.ill;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls.beq) begin
                    PCWrite    = 1'b1;
                    PCSrc      = zero ? PCS_BR : PCS_PC4;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (cls.lw || cls.sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                DMOp     = DM_WORD;
                MemWrite = cls.sw;
                if (mem_ready) begin
                    if (cls.sw) begin
                        PCWrite    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
                if (cls.add || cls.sub) begin
                    RegDst = RD_RD;
                end else if (cls.lw) begin
                    MemtoReg = M2R_DM;
                end else if (cls.jal) begin
                    RegDst   = RD_RA;
                    MemtoReg = M2R_PC4;
                    PCSrc    = PCS_JAL;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // ALU/extender controls follow op_q from DECODE through WB so the
        // immediate and ALU result stay stable while the datapath uses them.
        if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            if (cls.add) begin
                ALUOp = ALU_ADD;
            end else if (cls.sub) begin
                ALUOp = ALU_SUB;
            end else if (cls.ori) begin
                ALUOp  = ALU_OR;
                ALUSrc = 1'b1;
            end else if (cls.lui) begin
                ALUOp  = ALU_LUI;
                ALUSrc = 1'b1;
            end else if (cls.lw || cls.sw) begin
                ALUOp  = ALU_ADD;
                ALUSrc = 1'b1;
                ExtOp  = 1'b1;
            end else if (cls.beq) begin
                ALUOp = ALU_SUB;
                ExtOp = 1'b1;
            end
        end

        if (reset) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            mem_req    = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl against a per-instruction stage-path model.
module tb_multicycle_ctrl;

    localparam int CW = 4;
    localparam int ST_F = 0, ST_D = 1, ST_E = 2, ST_M = 3, ST_W = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    opcode = '0, funct = '0;
    logic          zero = 1'b0, mem_ready = 1'b0;
    logic          IRWrite, PCWrite, RegWrite, MemWrite, mem_req;
    logic          ALUSrc, ExtOp, instr_done, illegal;
    logic [2:0]    PCSrc, RegDst, MemtoReg, ALUOp, DMOp, state;
    logic [CW-1:0] retired;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .mem_req(mem_req), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .ExtOp(ExtOp), .DMOp(DMOp), .state(state),
        .instr_done(instr_done), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef enum int {C_ADD, C_SUB, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL, C_JR, C_NOP, C_ILL} cls_e;

    typedef struct packed {
        logic [2:0] st;
        logic       irw;
        logic       pcw;
        logic [2:0] pcsrc;
        logic       rw;
        logic [2:0] regdst;
        logic [2:0] m2r;
        logic       mw;
        logic       mreq;
        logic [2:0] aluop;
        logic       alusrc;
        logic       extop;
        logic [2:0] dmop;
        logic       done;
        logic       ill;
    } outs_t;

    outs_t         exp_o, act_o;
    logic [CW-1:0] exp_ret = '0;
    bit            chk_en = 1'b0;
    int            n_chk = 0, n_pass = 0;
    int            run = 0;

    // Cycles spent on the current instruction, counting its FETCH as 1.
    always @(posedge clk) begin
        if (reset) run <= 0;
        else if (state == 3'd0) run <= 1;
        else run <= run + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            act_o = {state, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, MemtoReg,
                     MemWrite, mem_req, ALUOp, ALUSrc, ExtOp, DMOp, instr_done, illegal};
            n_chk++;
            if (act_o === exp_o) n_pass++;
            else $display("FAIL outputs t=%0t: got %h expected %h", $time, act_o, exp_o);
            n_chk++;
            if (retired === exp_ret) n_pass++;
            else $display("FAIL retired t=%0t: got %0d expected %0d", $time, retired, exp_ret);
        end
    end

    task automatic pin(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                6'h20: return C_ADD;
                6'h22: return C_SUB;
                6'h08: return C_JR;
                6'h00: return C_NOP;
                default: return C_ILL;
            endcase
            6'h0D: return C_ORI;
            6'h23: return C_LW;
            6'h2B: return C_SW;
            6'h04: return C_BEQ;
            6'h0F: return C_LUI;
            6'h03: return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic outs_t stage_out(input int stg, input cls_e c, input logic z, input bit last_m);
        outs_t o;
        o = '0;
        o.st = 3'(stg);
        case (stg)
            ST_F: o.irw = 1'b1;
            ST_D: begin
                if (c == C_JR) begin o.pcw = 1; o.pcsrc = 3; o.done = 1; end
                if (c == C_NOP || c == C_ILL) begin o.pcw = 1; o.done = 1; o.ill = (c == C_ILL); end
            end
            ST_E: if (c == C_BEQ) begin o.pcw = 1; o.pcsrc = z ? 3'd1 : 3'd0; o.done = 1; end
            ST_M: begin
                o.mreq = 1; o.dmop = 1; o.mw = (c == C_SW);
                if (last_m && c == C_SW) begin o.pcw = 1; o.done = 1; end
            end
            ST_W: begin
                o.rw = 1; o.pcw = 1; o.done = 1;
                case (c)
                    C_ADD, C_SUB: o.regdst = 1;
                    C_LW:         o.m2r = 1;
                    C_JAL:        begin o.regdst = 2; o.m2r = 2; o.pcsrc = 2; end
                    default:      ;
                endcase
            end
            default: ;
        endcase
        if (stg != ST_F) begin
            case (c)
                C_ADD:       o.aluop = 2;
                C_SUB:       o.aluop = 6;
                C_ORI:       begin o.aluop = 1; o.alusrc = 1; end
                C_LUI:       begin o.aluop = 3; o.alusrc = 1; end
                C_LW, C_SW:  begin o.aluop = 2; o.alusrc = 1; o.extop = 1; end
                C_BEQ:       begin o.aluop = 6; o.extop = 1; end
                default:     ;
            endcase
        end
        return o;
    endfunction

    function automatic outs_t gate(input outs_t i);
        outs_t o;
        o = i;
        o.irw = 0; o.pcw = 0; o.rw = 0; o.mw = 0; o.mreq = 0; o.done = 0; o.ill = 0;
        return o;
    endfunction

    task automatic cyc(input outs_t e);
        exp_o  = e;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // abort_at: -1 none, -2 pick a random stage, else reset on that stage index.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int w,
                            input logic z, input int abort_at);
        int    path[$];
        cls_e  c;
        outs_t e;
        bit    last_m;
        c = classify(op, fn);
        path = {ST_F, ST_D};
        case (c)
            C_ADD, C_SUB, C_ORI, C_LUI: begin path.push_back(ST_E); path.push_back(ST_W); end
            C_BEQ: path.push_back(ST_E);
            C_JAL: path.push_back(ST_W);
            C_LW, C_SW: begin
                path.push_back(ST_E);
                for (int k = 0; k <= w; k++) path.push_back(ST_M);
                if (c == C_LW) path.push_back(ST_W);
            end
            default: ;
        endcase
        if (abort_at == -2) abort_at = $urandom_range(0, path.size() - 1);
        for (int i = 0; i < path.size(); i++) begin
            last_m    = (path[i] == ST_M) && ((i + 1 == path.size()) || (path[i+1] != ST_M));
            opcode    = (i == 0) ? op : 6'($urandom);
            funct     = (i == 0) ? fn : 6'($urandom);
            zero      = (path[i] == ST_E) ? z : 1'($urandom);
            mem_ready = (path[i] == ST_M) ? last_m : 1'($urandom);
            e = stage_out(path[i], c, z, last_m);
            if (i == abort_at) begin
                reset = 1'b1;
                cyc(gate(e));
                reset = 1'b0;
                exp_ret = '0;
                return;
            end
            cyc(e);
            if (e.done) exp_ret++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] rop, rfn;
        int         k;
        reset = 1'b1;
        @(posedge clk);
        #1;
        pin("reset state", int'(state), 0);
        pin("reset retired", int'(retired), 0);
        cyc(gate(stage_out(ST_F, C_NOP, 1'b0, 1'b0)));
        cyc(gate(stage_out(ST_F, C_NOP, 1'b0, 1'b0)));
        reset = 1'b0;

        do_instr(6'h00, 6'h20, 0, 1'b0, -1);
        pin("add latency", run, 4);
        pin("add retired", int'(retired), 1);
        do_instr(6'h23, 6'h00, 3, 1'b0, -1);
        pin("lw w3 latency", run, 8);
        do_instr(6'h2B, 6'h00, 0, 1'b0, -1);
        pin("sw w0 latency", run, 4);
        do_instr(6'h04, 6'h00, 0, 1'b1, -1);
        pin("beq taken latency", run, 3);
        do_instr(6'h04, 6'h00, 0, 1'b0, -1);
        pin("beq untaken latency", run, 3);
        do_instr(6'h03, 6'h00, 0, 1'b0, -1);
        pin("jal latency", run, 3);
        do_instr(6'h00, 6'h08, 0, 1'b0, -1);
        pin("jr latency", run, 2);
        do_instr(6'h3F, 6'h00, 0, 1'b0, -1);
        pin("illegal retired", int'(retired), 8);

        do_instr(6'h23, 6'h00, 2, 1'b0, 4);
        pin("abort state", int'(state), 0);
        pin("abort retired", int'(retired), 0);

        for (int i = 0; i < 15; i++) do_instr(6'h00, 6'h00, 0, 1'b0, -1);
        pin("retired all-ones", int'(retired), 15);
        do_instr(6'h00, 6'h00, 0, 1'b0, -1);
        pin("retired wrap", int'(retired), 0);

        for (int i = 0; i < 400; i++) begin
            k   = $urandom_range(0, 11);
            rfn = 6'($urandom);
            case (k)
                0: begin rop = 6'h00; rfn = 6'h20; end
                1: begin rop = 6'h00; rfn = 6'h22; end
                2: rop = 6'h0D;
                3: rop = 6'h23;
                4: rop = 6'h2B;
                5: rop = 6'h04;
                6: rop = 6'h0F;
                7: rop = 6'h03;
                8: begin rop = 6'h00; rfn = 6'h08; end
                9: begin rop = 6'h00; rfn = 6'h00; end
                default: rop = 6'($urandom);
            endcase
            do_instr(rop, rfn, $urandom_range(0, 3), 1'($urandom),
                     ($urandom_range(0, 29) == 0) ? -2 : -1);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
